mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Parameters
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 64, giving the data memory size in 32-bit words (power of two).

Interface
REQ-002 The module SHALL have these ports: Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 The module SHALL have these ports: i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have these ports: i_enable  in  1  stage advance; i_flush  in  1  bubble insert; i_halt  in  1  halt token from EX/MEM.
REQ-005 The module SHALL have these ports: In_ControlSignal  in  32  control word with bit0 MemRead, bit1 MemWrite, bits[3:2] size (00 byte, 01 half, 10 word, 11 treated as word), bit4 unsigned load, bit5 RegWrite, bit6 MemToReg; other bits ignored.
REQ-006 The module SHALL have these ports: In_ALUResult  in  32  byte address / ALU value; In_RegRTData  in  32  store data; In_RegDst  in  5  destination register; In_PCAdder  in  32  PC+4.
REQ-007 The module SHALL have these ports: i_dbg_addr  in  log2(DEPTH_WORDS)  debug word index; o_dbg_data  out  32  combinational memory word at i_dbg_addr.
REQ-008 The module SHALL have these registered outputs: Out_RegWrite 1, Out_MemToReg 1, Out_ReadData 32, Out_ALUResult 32, Out_RegDst 5, Out_PCAdder 32, o_halt 1, o_misaligned 1.

Function
REQ-009 Word index SHALL be In_ALUResult[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-010 Memory SHALL be little-endian: byte lane k = word bits [8k+7:8k], lane chosen by address[1:0].
REQ-011 A store SHALL commit on the rising edge where i_enable=1, i_flush=0, MemWrite=1 and the access is aligned; byte store writes lane addr[1:0] with data[7:0]; half store writes lanes {addr[1],0} and {addr[1],1} with data[15:0]; word store writes all lanes; unwritten lanes SHALL keep their value.
REQ-012 A load SHALL read the addressed word combinationally and register the extracted result into Out_ReadData on the same edge: 1-cycle latency; byte/half zero-extended when bit4=1, else sign-extended.
REQ-013 Out_ReadData SHALL be 0 when MemRead=0.
REQ-014 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, for MemRead or MemWrite; then no memory write, Out_ReadData=0, Out_RegWrite=0, o_misaligned=1 for that latched instruction; o_misaligned=0 otherwise.
REQ-015 On an enabled edge, Out_RegWrite, Out_MemToReg, Out_ALUResult, Out_RegDst, Out_PCAdder, o_halt SHALL latch bit5, bit6, In_ALUResult, In_RegDst, In_PCAdder, i_halt.
REQ-016 i_flush=1 SHALL take priority over i_enable: all registered outputs cleared to 0, store suppressed.
REQ-017 i_enable=0 and i_flush=0: all registered outputs and memory SHALL hold.
REQ-018 A load on the cycle following a store to the same word SHALL return the newly written data; a store and a debug read of the same word in one cycle SHALL return the old word on o_dbg_data until the edge.

Reset
REQ-019 i_reset_n=0 SHALL immediately clear every registered output to 0, independent of Clock, and override i_flush/i_enable.
REQ-020 Reset SHALL NOT clear memory contents; a store pending on a reset-asserted edge SHALL NOT commit.

Verification
REQ-021 SW 0x11223344 at addr 0x08, then LW 0x08 -> Out_ReadData=0x11223344 one edge after LW, Out_MemToReg=1.
REQ-022 After REQ-021, SB 0xAB at addr 0x09, LB 0x09 -> 0xFFFFFFAB; LBU 0x09 -> 0x000000AB; LW 0x08 -> 0x1122AB44.
REQ-023 SH 0x8001 at 0x0A, LH 0x0A -> 0xFFFF8001; LHU -> 0x00008001; LW 0x08 -> 0x8001AB44.
REQ-024 LW at 0x06 and SW at 0x05 -> o_misaligned=1, Out_RegWrite=0, Out_ReadData=0; word 0x04 unchanged via o_dbg_data.
REQ-025 SW with i_flush=1 -> memory unchanged, all outputs 0; with i_enable=0 -> outputs hold prior values; i_halt=1 enabled -> o_halt=1 next edge.
REQ-026 Assert i_reset_n=0 mid-cycle -> outputs 0 before next edge; o_dbg_data still shows previously stored words; SW 0x100+0x08 writes word index 2 (wrap, DEPTH_WORDS=64).

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: little-endian byte-addressable data memory with sized,
// sign/zero-extending loads, alignment checking and registered MEM/WB outputs.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           Clock,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic                           i_flush,
  input  logic                           i_halt,
  input  logic [31:0]                    In_ControlSignal,
  input  logic [31:0]                    In_ALUResult,
  input  logic [31:0]                    In_RegRTData,
  input  logic [4:0]                     In_RegDst,
  input  logic [31:0]                    In_PCAdder,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_dbg_addr,
  output logic [31:0]                    o_dbg_data,
  output logic                           Out_RegWrite,
  output logic                           Out_MemToReg,
  output logic [31:0]                    Out_ReadData,
  output logic [31:0]                    Out_ALUResult,
  output logic [4:0]                     Out_RegDst,
  output logic [31:0]                    Out_PCAdder,
  output logic                           o_halt,
  output logic                           o_misaligned
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];

  logic          mem_read;
  logic          mem_write;
  logic [1:0]    size;
  logic          is_unsigned;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          align_err;
  logic          misaligned;
  logic          do_store;
  logic [31:0]   read_data_next;

  assign mem_read    = In_ControlSignal[0];
  assign mem_write   = In_ControlSignal[1];
  assign size        = In_ControlSignal[3:2];
  assign is_unsigned = In_ControlSignal[4];
  assign lane        = In_ALUResult[1:0];
  assign word_idx    = In_ALUResult[AW+1:2];

  assign rd_word    = mem[word_idx];
  assign o_dbg_data = mem[i_dbg_addr];
  assign rd_byte    = rd_word[{lane, 3'b000} +: 8];
  assign rd_half    = rd_word[{lane[1], 4'b0000} +: 16];

  // Narrow store data is replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    align_err = 1'b0;
    load_data = rd_word;
    wr_data   = In_RegRTData;
    wr_be     = 4'b1111;
    case (size)
      2'b00: begin
        load_data = {{24{rd_byte[7] & ~is_unsigned}}, rd_byte};
        wr_data   = {4{In_RegRTData[7:0]}};
        wr_be     = 4'b0001 << lane;
      end
      2'b01: begin
        align_err = lane[0];
        load_data = {{16{rd_half[15] & ~is_unsigned}}, rd_half};
        wr_data   = {2{In_RegRTData[15:0]}};
        wr_be     = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        align_err = (lane != 2'b00);
      end
    endcase
  end

  assign misaligned     = align_err & (mem_read | mem_write);
  assign do_store       = i_reset_n & i_enable & ~i_flush & mem_write & ~misaligned;
  assign read_data_next = (mem_read & ~misaligned) ? load_data : '0;

  always_ff @(posedge Clock) begin
    if (do_store) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge Clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      Out_RegWrite  <= 1'b0;
      Out_MemToReg  <= 1'b0;
      Out_ReadData  <= '0;
      Out_ALUResult <= '0;
      Out_RegDst    <= '0;
      Out_PCAdder   <= '0;
      o_halt        <= 1'b0;
      o_misaligned  <= 1'b0;
    end else if (i_flush) begin
      Out_RegWrite  <= 1'b0;
      Out_MemToReg  <= 1'b0;
      Out_ReadData  <= '0;
      Out_ALUResult <= '0;
      Out_RegDst    <= '0;
      Out_PCAdder   <= '0;
      o_halt        <= 1'b0;
      o_misaligned  <= 1'b0;
    end else if (i_enable) begin
      Out_RegWrite  <= In_ControlSignal[5] & ~misaligned;
      Out_MemToReg  <= In_ControlSignal[6];
      Out_ReadData  <= read_data_next;
      Out_ALUResult <= In_ALUResult;
      Out_RegDst    <= In_RegDst;
      Out_PCAdder   <= In_PCAdder;
      o_halt        <= i_halt;
      o_misaligned  <= misaligned;
    end
  end

endmodule
